mux_pipe_nxw: RTL and testbench
===============================

Name: mux_pipe_nxw

Overview:
- Parametrised successor to the 2-input, 64-bit combinational mux.
- Selects one of NUM_IN operands of WIDTH bits and registers the result behind a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under backpressure.
- Sits between the register-read/bypass stage and the issue/execute stage. Downstream stalls never corrupt or drop a selected operand.

Parameters:
NUM_IN, 4, number of input operands (2..16)
WIDTH, 64, bits per operand
SEL_W, $clog2(NUM_IN) (minimum 1), select width; derived, not overridden

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents sel/mux_ins this cycle
in_ready  output  1  block can accept this cycle
sel  input  SEL_W  operand index
mux_ins  input  [NUM_IN-1:0][WIDTH-1:0]  operand k is mux_ins[k]
out_valid  output  1  out_data/out_sel_err hold a result
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  selected operand, registered
out_sel_err  output  1  result came from an out-of-range sel
out_parity  output  1  only with MUX_PARITY_EN: even parity of out_data

Behaviour:
- Reset (reset_n low, async): main_valid=0, skid_valid=0, all data/err regs=0.
  - Therefore out_valid=0, out_data=0, out_sel_err=0, in_ready=1.
  - Reset mid-transfer discards both entries; no result is emitted after release.
- Transfers:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
- in_ready = !skid_valid. It is driven only from a register, with no combinational path from out_ready.
- Select:
  - sel < NUM_IN: value = mux_ins[sel], err = 0.
  - sel >= NUM_IN (non-power-of-2 NUM_IN only): value = 0, err = 1. Data travels with its err bit.
- Latency: an accepted item appears on out_data one cycle later, provided the main register is empty or draining.
- State, as {skid_valid, main_valid}:
  - EMPTY 00: accept -> load main -> ONE.
  - ONE 01:
    - accept & emit -> main reloads -> ONE.
    - accept & !emit -> load skid -> FULL.
    - !accept & emit -> EMPTY.
    - otherwise hold.
  - FULL 11: in_ready=0.
    - emit -> main takes skid, skid clears -> ONE.
    - otherwise hold; out_data stays stable.
  - State 10 is unreachable.
- Ordering: strict FIFO. Skid contents always precede any newer input.
- Stability: while out_valid=1 and out_ready=0, out_data/out_sel_err do not change, whatever the inputs do.
- in_valid while in_ready=0 is ignored. Upstream must hold its data; no capture occurs.
- Throughput: 1 item/cycle sustained with out_ready held high.

Optional Feature:
- Macro: MUX_PARITY_EN.
- Defined:
  - out_parity port exists.
  - A parity bit (^value) is computed at capture and stored alongside data in both main and skid.
  - out_parity = ^out_data whenever out_valid. Reset value 0.
  - Out-of-range sel yields parity 0.
- Undefined: out_parity port and its storage are absent. All other behaviour is identical.

Test Plan:
1. Reset: reset_n=0 asynchronously mid-cycle with both entries full -> out_valid=0, out_data=0, in_ready=1 immediately, before the next clk edge. No output after release.
2. Passthrough (NUM_IN=4, out_ready=1):
   - Stimulus: mux_ins = {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA}, sel = 0,1,2,3 on consecutive cycles.
   - Response: out_data = AAAA, BBBB, CCCC, DDDD one cycle later; out_valid high 4 cycles; in_ready never drops.
3. Backpressure:
   - Stimulus: out_ready=0 while items sel=1 then sel=2 are sent.
   - Response: out_data=BBBB held, in_ready=0 after the 2nd accept, 3rd item (sel=3) is not taken.
   - Then out_ready=1 -> BBBB, CCCC, DDDD emitted in order with no loss or duplication.
4. Out-of-range (NUM_IN=3, SEL_W=2):
   - sel=3 -> out_data=0, out_sel_err=1.
   - Following sel=2 -> out_sel_err=0 with mux_ins[2].
5. Random stress: random in_valid/out_ready for 10k cycles against a scoreboard queue.
   - Output sequence equals accepted sequence.
   - Check fires if out_data changes while out_valid & !out_ready.
6. MUX_PARITY_EN: mux_ins[0]=64'h1 -> out_parity=1; mux_ins[1]=64'h3 -> out_parity=0. The build without the macro compiles without the port.

Source files
------------

// File: rtl/mux_pipe_nxw.sv
// mux_pipe_nxw: NUM_IN x WIDTH operand select, registered behind a 2-entry skid buffer.
// Define MUX_PARITY_EN to carry an even-parity bit with every entry (adds out_parity).
module mux_pipe_nxw #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 64,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SEL_W-1:0]               sel,
  input  logic [NUM_IN-1:0][WIDTH-1:0]   mux_ins,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
`ifdef MUX_PARITY_EN
  output logic                           out_parity,
`endif
  output logic                           out_sel_err
);

  typedef struct packed {
`ifdef MUX_PARITY_EN
    logic             par;
`endif
    logic             err;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t cap;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept, emit;

  // Unmatched sel (only possible for non-power-of-2 NUM_IN) yields zero data with err set.
  always_comb begin
    cap     = '0;
    cap.err = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        cap.data = mux_ins[k];
        cap.err  = 1'b0;
      end
    end
`ifdef MUX_PARITY_EN
    cap.par = ^cap.data;
`endif
  end

  always_comb begin
    accept       = in_valid & ~skid_valid_q;
    emit         = main_valid_q & out_ready;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (emit | ~main_valid_q) begin
      // Main is free: skid content always goes first to keep FIFO order.
      main_valid_d = skid_valid_q | accept;
      skid_valid_d = 1'b0;
      if (skid_valid_q) begin
        main_d = skid_q;
      end else if (accept) begin
        main_d = cap;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = cap;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready    = ~skid_valid_q;
  assign out_valid   = main_valid_q;
  assign out_data    = main_q.data;
  assign out_sel_err = main_q.err;
`ifdef MUX_PARITY_EN
  assign out_parity  = main_q.par;
`endif

endmodule

// File: tb/tb_mux_pipe_nxw.sv
// Bench for mux_pipe_nxw: queue model on a NUM_IN=4 instance, directed
// literal checks on NUM_IN=4 and NUM_IN=3 instances.
module tb_mux_pipe_nxw;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic              in_valid, in_ready, out_valid, out_ready, out_sel_err;
  logic [1:0]        sel;
  logic [3:0][63:0]  ins4;
  logic [63:0]       out_data;

  logic              in_valid3, in_ready3, out_valid3, out_ready3, out_sel_err3;
  logic [1:0]        sel3;
  logic [2:0][63:0]  ins3;
  logic [63:0]       out_data3;
`ifdef MUX_PARITY_EN
  logic              out_parity, out_parity3;
`endif

  mux_pipe_nxw #(.NUM_IN(4), .WIDTH(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mux_ins(ins4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
`ifdef MUX_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_sel_err(out_sel_err)
  );

  mux_pipe_nxw #(.NUM_IN(3), .WIDTH(64)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .sel(sel3), .mux_ins(ins3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .out_data(out_data3),
`ifdef MUX_PARITY_EN
    .out_parity(out_parity3),
`endif
    .out_sel_err(out_sel_err3)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: items accepted but not yet emitted, in order. The block holds
  // at most two, the head is what out_data shows.
  typedef struct {
    logic [63:0] data;
    logic        err;
  } item_t;
  item_t q[$];

  function automatic item_t pick(input logic [1:0] s,
                                 input logic [3:0][63:0] v);
    item_t it;
    it.data = (int'(s) < 4) ? v[s] : 64'h0;
    it.err  = (int'(s) < 4) ? 1'b0 : 1'b1;
    return it;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
    end else begin
      if (q.size() > 0 && out_ready) begin
        if (in_valid && q.size() < 2) begin
          q.push_back(pick(sel, ins4));
        end
        q.pop_front();
      end else if (in_valid && q.size() < 2) begin
        q.push_back(pick(sel, ins4));
      end
    end
  end

  initial begin
    logic        hold_prev;
    logic [63:0] prev_data;
    logic        prev_err;
    hold_prev = 1'b0;
    prev_data = '0;
    prev_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("m_in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
          chk("m_out_data", out_data, q[0].data);
          chk("m_sel_err", 64'(out_sel_err), 64'(q[0].err));
`ifdef MUX_PARITY_EN
          chk("m_parity", 64'(out_parity), 64'(^q[0].data));
`endif
        end
        if (hold_prev) begin
          chk("stable_data", out_data, prev_data);
          chk("stable_err", 64'(out_sel_err), 64'(prev_err));
        end
        hold_prev = out_valid && !out_ready;
        prev_data = out_data;
        prev_err  = out_sel_err;
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    sel        = '0;
    ins4       = '0;
    out_ready  = 1'b0;
    in_valid3  = 1'b0;
    sel3       = '0;
    ins3       = '0;
    out_ready3 = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sel_err", 64'(out_sel_err), 64'd0);
    step();
    step();
    reset_n = 1'b1;

    // Passthrough
    ins4 = {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA};
    out_ready = 1'b1;
    step();
    in_valid = 1'b1;
    sel = 2'd0;
    step();
    chk("pt_0", out_data, 64'hAAAA);
    sel = 2'd1;
    step();
    chk("pt_1", out_data, 64'hBBBB);
    chk("pt_rdy1", 64'(in_ready), 64'd1);
    sel = 2'd2;
    step();
    chk("pt_2", out_data, 64'hCCCC);
    sel = 2'd3;
    step();
    chk("pt_3", out_data, 64'hDDDD);
    chk("pt_v3", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    step();
    chk("pt_drained", 64'(out_valid), 64'd0);

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    sel = 2'd1;
    step();
    chk("bp_first", out_data, 64'hBBBB);
    chk("bp_rdy_one", 64'(in_ready), 64'd1);
    sel = 2'd2;
    step();
    chk("bp_rdy_full", 64'(in_ready), 64'd0);
    chk("bp_hold1", out_data, 64'hBBBB);
    sel = 2'd3;
    step();
    chk("bp_hold2", out_data, 64'hBBBB);
    chk("bp_still_full", 64'(in_ready), 64'd0);
    step();
    chk("bp_hold3", out_data, 64'hBBBB);
    out_ready = 1'b1;
    step();
    chk("bp_emit_c", out_data, 64'hCCCC);
    chk("bp_rdy_back", 64'(in_ready), 64'd1);
    step();
    chk("bp_emit_d", out_data, 64'hDDDD);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Out-of-range select on NUM_IN=3
    ins3 = {64'hCCCC, 64'hBBBB, 64'hAAAA};
    in_valid3 = 1'b1;
    sel3 = 2'd3;
    step();
    chk("oor_valid", 64'(out_valid3), 64'd1);
    chk("oor_data", out_data3, 64'd0);
    chk("oor_err", 64'(out_sel_err3), 64'd1);
    sel3 = 2'd2;
    step();
    chk("inr_data", out_data3, 64'hCCCC);
    chk("inr_err", 64'(out_sel_err3), 64'd0);
    in_valid3 = 1'b0;
    step();
    chk("oor_drained", 64'(out_valid3), 64'd0);

`ifdef MUX_PARITY_EN
    ins4[0] = 64'h1;
    ins4[1] = 64'h3;
    in_valid = 1'b1;
    sel = 2'd0;
    step();
    chk("par_one", 64'(out_parity), 64'd1);
    sel = 2'd1;
    step();
    chk("par_zero", 64'(out_parity), 64'd0);
    in_valid = 1'b0;
    step();
`endif

    // Async reset with both entries full
    out_ready = 1'b0;
    ins4 = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
    in_valid = 1'b1;
    sel = 2'd0;
    step();
    sel = 2'd1;
    step();
    in_valid = 1'b0;
    chk("full_before_rst", 64'(in_ready), 64'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data", out_data, 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_v0", 64'(out_valid), 64'd0);
    step();
    chk("post_rst_v1", 64'(out_valid), 64'd0);

    // Random stress, upstream holds a refused item
    for (int i = 0; i < 10000; i++) begin
      step();
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 9) < 7);
        sel = 2'($urandom_range(0, 3));
        for (int k = 0; k < 4; k++) ins4[k] = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 9) < 6);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    chk("stress_drained", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
